// File: rtl/block_data_memory_pkg.sv
// Shared types and defaults for the block-granular data memory.
// The state encoding is fixed so that state can be observed as a plain 2-bit value.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_e;

  localparam int DMEM_ADDR_W     = 6;
  localparam int DMEM_DATA_W     = 32;
  localparam int DMEM_LATENCY    = 5;
  localparam int BYTES_PER_BLOCK = 4;
  // Wide enough for LATENCY-1 over the whole legal LATENCY range of 1..15.
  localparam int CNT_W           = 4;

endpackage

// File: rtl/block_data_memory_if.sv
// Cache-to-memory block port. The cache drives the request side (master) and
// the memory answers with readdata/busywait (slave).
interface block_data_memory_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );

endinterface

// File: rtl/block_data_memory_latency_counter.sv
// Down-counter that times the BUSY phase of an access.
// load wins over decrement, and the count never wraps below zero.
module mem_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec_en,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec_en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block data memory answering the data cache's memory port: one block access
// per request, busywait held for LATENCY edges, readdata registered.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic                 clock,
  input  logic                 reset,
  block_data_memory_if.slave   mem
);

  localparam int DEPTH = 1 << ADDR_W;

  dmem_state_e       state_reg;
  dmem_state_e       state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_write_q;
  logic [DATA_W-1:0] readdata_reg;

  logic              busywait_comb;
  logic              accept;
  logic              complete;
  logic              cnt_zero;
  logic              cnt_dec;

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic [DEPTH-1:0]  word_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // busywait follows the request combinationally in IDLE so the cache never
  // sees it low on the edge right after raising a request.
  always_comb begin
    state_next    = state_reg;
    busywait_comb = 1'b0;
    accept        = 1'b0;
    complete      = 1'b0;
    case (state_reg)
      IDLE: begin
        busywait_comb = mem.read | mem.write;
        if (mem.read | mem.write) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busywait_comb = 1'b1;
        if (cnt_zero) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // The cache still holds its old request here; ignore it for a cycle.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cnt_dec = (state_reg == BUSY) && !cnt_zero;

  mem_latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (CNT_W'(LATENCY - 1)),
    .dec_en     (cnt_dec),
    .zero       (cnt_zero)
  );

  // Request is captured on acceptance so later input changes cannot disturb it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= mem.address;
      wdata_q    <= mem.writedata;
      op_write_q <= mem.write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_reg <= '0;
    end else if (complete && !op_write_q) begin
      readdata_reg <= mem_array[addr_q];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = complete && op_write_q && (addr_q == ADDR_W'(gi));
    end
  endgenerate

  // The array is cleared by reset, so it lives in registers rather than block RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_array[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) begin
          mem_array[i] <= wdata_q;
        end
      end
    end
  end

  assign mem.readdata = readdata_reg;
  assign mem.busywait = busywait_comb;

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: default build (LATENCY=5) plus a
// LATENCY=1 build; expected read data comes from a bench-side memory model.
module tb_block_data_memory;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  block_data_memory_if #(.ADDR_W(6), .DATA_W(32)) bus  ();
  block_data_memory_if #(.ADDR_W(6), .DATA_W(32)) bus1 ();

  block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut (
    .clock (clock),
    .reset (reset),
    .mem   (bus.slave)
  );

  block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .mem   (bus1.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_mem [64];
  logic [31:0] model_rd;
  logic [31:0] exp_q [$];

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_rd = '0;
    exp_q.delete();
  endtask

  // Drive a request on the default build and record what it should produce.
  task automatic drive_req(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = d;
    if (wr) model_mem[a] = d;
    else if (rd) exp_q.push_back(model_mem[a]);
  endtask

  task automatic release_req();
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  // One full access: request on a negedge, wait for DONE, check latency and data.
  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [5:0] a, input logic [31:0] d);
    int          n;
    logic [31:0] exp;
    @(negedge clock);
    drive_req(rd, wr, a, d);
    #1;
    total++;
    if (bus.busywait !== 1'b1)
      $display("FAIL %s busywait_req: got %b want 1", nm, bus.busywait);
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (bus.busywait && n < 40);
    total++;
    if (bus.busywait !== 1'b0 || n != 6) begin
      bad++;
      $display("FAIL %s latency: edges=%0d busywait=%b want edges=6 busywait=0", nm, n, bus.busywait);
    end
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      model_rd = exp;
    end else begin
      exp = model_rd;
    end
    total++;
    if (bus.readdata !== exp) begin
      bad++;
      $display("FAIL %s readdata: got %h want %h", nm, bus.readdata, exp);
    end else begin
      $display("%s: addr=%h rd=%b wr=%b readdata=%h edges=%0d", nm, a, rd, wr, bus.readdata, n);
    end
    @(negedge clock);
    release_req();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    release_req();
    bus.address = '0; bus.writedata = '0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0; bus1.writedata = '0;
    model_clear();
    #12;
    total++;
    if (bus.busywait !== 1'b0 || bus.readdata !== 32'h0 || bus1.busywait !== 1'b0 || bus1.readdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: busywait=%b readdata=%h busywait1=%b readdata1=%h want 0/0/0/0",
               bus.busywait, bus.readdata, bus1.busywait, bus1.readdata);
    end else begin
      $display("reset: busywait=0 readdata=0");
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_read_after_reset();
    access("read_0x00", 1'b1, 1'b0, 6'h00, 32'h0);
  endtask

  task automatic test_write_read();
    access("write_0x12", 1'b0, 1'b1, 6'h12, 32'hA1B2C3D4);
    access("read_0x12", 1'b1, 1'b0, 6'h12, 32'h0);
    total++;
    if (bus.readdata[7:0] !== 8'hD4) begin
      bad++;
      $display("FAIL byte0_0x12: got %h want d4", bus.readdata[7:0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b1; bus.address = 6'h07; bus.writedata = 32'hDEADBEEF;
    @(posedge clock);
    repeat (3) @(posedge clock);
    #2;
    release_req();
    reset = 1'b1;
    #1;
    total++;
    if (bus.busywait !== 1'b0 || bus.readdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_busy: busywait=%b readdata=%h want 0/0", bus.busywait, bus.readdata);
    end else begin
      $display("reset_mid_busy: busywait=0 readdata=0");
    end
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    access("read_0x07_after_abort", 1'b1, 1'b0, 6'h07, 32'h0);
  endtask

  task automatic test_dirty_eviction();
    int          n;
    logic [31:0] exp;
    access("prefill_0x0A", 1'b0, 1'b1, 6'h0A, 32'h0BADF00D);
    @(negedge clock);
    drive_req(1'b0, 1'b1, 6'h2A, 32'h11223344);
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (bus.busywait && n < 40);
    // Still in DONE with the write held: switch to the read and make sure DONE ignores it.
    @(negedge clock);
    drive_req(1'b1, 1'b0, 6'h0A, 32'h0);
    #1;
    total++;
    if (bus.busywait !== 1'b0) begin
      bad++;
      $display("FAIL evict_done_ignore: busywait=%b want 0", bus.busywait);
    end
    do begin
      @(posedge clock); #1; n++;
    end while (bus.busywait && n < 60);
    exp = exp_q.pop_front();
    model_rd = exp;
    total++;
    if (n != 13 || bus.busywait !== 1'b0) begin
      bad++;
      $display("FAIL evict_latency: edges_after_first_accept=%0d want 12", n - 1);
    end
    total++;
    if (bus.readdata !== exp) begin
      bad++;
      $display("FAIL evict_readdata: got %h want %h", bus.readdata, exp);
    end else begin
      $display("evict: read 0x0a readdata=%h edges=%0d", bus.readdata, n - 1);
    end
    @(negedge clock);
    release_req();
    access("read_0x2A", 1'b1, 1'b0, 6'h2A, 32'h0);
  endtask

  task automatic test_both_high();
    access("both_0x05", 1'b1, 1'b1, 6'h05, 32'h55AA55AA);
    access("read_0x05", 1'b1, 1'b0, 6'h05, 32'h0);
  endtask

  task automatic test_latency_one();
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      bus1.address   = 6'h3F;
      bus1.writedata = 32'hFFFFFFFF;
      bus1.write     = (k == 0);
      bus1.read      = (k == 1);
      n = 0;
      do begin
        @(posedge clock); #1; n++;
      end while (bus1.busywait && n < 40);
      total++;
      if (n != 2 || bus1.busywait !== 1'b0) begin
        bad++;
        $display("FAIL lat1_latency_%0d: edges=%0d want 2", k, n);
      end
      @(negedge clock);
      bus1.read = 1'b0; bus1.write = 1'b0;
    end
    total++;
    if (bus1.readdata !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL lat1_readdata: got %h want ffffffff", bus1.readdata);
    end else begin
      $display("lat1: read 0x3f readdata=%h", bus1.readdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_reset_mid_busy();
    test_dirty_eviction();
    test_both_high();
    test_latency_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Block-granular main data memory; the responder end of the data cache's memory port.
- Accepts one block read or block write per request and holds busywait high for a fixed, parameterised latency.
- On a read, returns a 32-bit block (4 bytes). On a write, stores one.
- Sits directly below data_cache; its ports connect one-to-one to the cache's mem_* signals.

Parameters:
- ADDR_W, 6: block address width. Depth is 2**ADDR_W = 64 blocks (256 bytes).
- DATA_W, 32: block width. Fixed at 4 bytes × 8 bits.
- LATENCY, 5: number of clock cycles spent in BUSY per access. Legal range 1..15.

Ports:
- clock  in  1: system clock, rising edge active.
- reset  in  1: asynchronous, active-high reset.
- read  in  1: block read request (cache mem_read).
- write  in  1: block write request (cache mem_write).
- address  in  ADDR_W: block address {tag, index}.
- writedata  in  DATA_W: block to store. Byte k is in bits [8k+7:8k].
- readdata  out  DATA_W: returned block. Registered.
- busywait  out  1: high while a request is pending or in service.

Behaviour:
- Interface rule: one clock (clock); reset is asynchronous and active-high (reset).
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, counter = 0, readdata = 0, busywait = 0.
  - All 64 array words cleared to 0.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - busywait = read | write, combinational. The cache therefore never samples busywait low on the edge after it raises a request.
  - On a rising edge with read | write = 1:
    - capture address, writedata and op (write has priority if both are high);
    - load counter with LATENCY-1;
    - go to BUSY.
- BUSY:
  - busywait = 1.
  - Inputs are ignored; the captured request completes even if read/write drop or address changes.
  - Each edge with counter != 0: decrement counter.
  - Edge with counter == 0:
    - read: readdata <= array[addr_q];
    - write: array[addr_q] <= wdata_q, readdata unchanged;
    - go to DONE.
  - busywait therefore falls exactly LATENCY edges after the acceptance edge.
- DONE:
  - busywait = 0. Requests are ignored for this one cycle (the cache is still holding the old request while it samples busywait low).
  - Next edge: go to IDLE unconditionally.
  - readdata is valid throughout DONE.
- readdata holds its last value until the next read completes or reset asserts.
- Back-to-back requests (dirty eviction: write then read) follow DONE→IDLE; the new request raises busywait combinationally in IDLE.
- Minimum per-access occupancy is LATENCY+1 cycles.
- Reset asserted in BUSY aborts the access; any pending write is discarded.
- read and write both high: treated as a write.
- Address wrap does not arise (full decode). X on address while BUSY has no effect because the address was captured.

Decomposition:
- Package dmem_pkg:
  - state enum IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - default ADDR_W/DATA_W/LATENCY constants;
  - BYTES_PER_BLOCK=4.
- Sub-module mem_latency_counter:
  - ports: load, load_value, decrement enable, zero flag;
  - same asynchronous active-high reset.
- Array, capture registers and FSM stay in the top module.

Test Plan:
- Reset mid-BUSY (reset high 3 cycles after accepting write to addr 0x07, data 0xDEADBEEF) -> busywait drops immediately; a later read of 0x07 returns 0x00000000.
- After reset, read 0x00 -> busywait high in the request cycle; low after 5 edges; readdata = 0x00000000.
- Write 0x12 with 0xA1B2C3D4, then read 0x12 -> second busywait falls 5 edges after its acceptance; readdata = 0xA1B2C3D4; byte [7:0] = 0xD4.
- Dirty eviction:
  - write 0x2A (0x11223344) held through DONE, then read 0x0A;
  - -> exactly two accesses, no duplicate write;
  - readdata = prior contents of 0x0A;
  - read data available 12 edges after the first acceptance.
- read and write both high on 0x05 with 0x55AA55AA -> treated as write; readdata unchanged; a later read returns 0x55AA55AA.
- LATENCY=1 build: read 0x3F after writing 0xFFFFFFFF -> busywait high for exactly one edge after acceptance; readdata = 0xFFFFFFFF.
